page_reg_loader: RTL and testbench



---
 rtl/page_reg_loader_pkg.sv | 16 +
 rtl/page_reg_loader_if.sv | 41 ++++
 rtl/page_reg_loader_lane_pick.sv | 26 ++
 rtl/page_reg_loader.sv | 138 +++++++++++++
 tb/tb_page_reg_loader.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/page_reg_loader_pkg.sv
// Shared types and constants for the page-register loader.
// Holds the FSM state enum, lane/byte sizing and the lane-mask type.
package page_loader_pkg;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;
    localparam int WORD_W = LANES * BYTE_W;

    typedef logic [LANES-1:0] lane_mask_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/page_reg_loader_if.sv
// Upstream word handshake plus page-register bank write bus.
// slave: loader side; master: upstream/bank side. in_be needs PAGE_LOADER_SKIP_EN.
interface page_reg_loader_if #(
    parameter int ENTRY_W = 3
);
    import page_loader_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  in_data;
    logic [ENTRY_W-1:0] in_entry;
`ifdef PAGE_LOADER_SKIP_EN
    lane_mask_t         in_be;
`endif
    logic [BYTE_W-1:0]  out_data;
    lane_mask_t         out_lane_en;
    logic [ENTRY_W-1:0] out_entry;
    logic               busy;
    logic               done;

`ifdef PAGE_LOADER_SKIP_EN
    modport slave (
        input  in_valid, in_data, in_entry, in_be,
        output in_ready, out_data, out_lane_en, out_entry, busy, done
    );
    modport master (
        output in_valid, in_data, in_entry, in_be,
        input  in_ready, out_data, out_lane_en, out_entry, busy, done
    );
`else
    modport slave (
        input  in_valid, in_data, in_entry,
        output in_ready, out_data, out_lane_en, out_entry, busy, done
    );
    modport master (
        output in_valid, in_data, in_entry,
        input  in_ready, out_data, out_lane_en, out_entry, busy, done
    );
`endif

endinterface

// File: rtl/page_reg_loader_lane_pick.sv
// Combinational lowest-set-bit lane picker.
// i_mask: pending lanes; o_idx/o_en: chosen lane; o_last: no lane left after it.
module page_lane_pick
    import page_loader_pkg::*;
(
    input  lane_mask_t i_mask,
    output logic [1:0] o_idx,
    output lane_mask_t o_en,
    output logic       o_last
);

    always_comb begin
        o_idx = 2'd0;
        o_en  = '0;
        // Walk high to low so the lowest set bit wins.
        for (int k = LANES - 1; k >= 0; k--) begin
            if (i_mask[k]) begin
                o_idx = 2'(k);
                o_en  = lane_mask_t'(1) << k;
            end
        end
        // An empty mask counts as last so a zero-lane word still completes.
        o_last = (i_mask & ~o_en) == '0;
    end

endmodule

// File: rtl/page_reg_loader.sv
// Serializes 32-bit words into four byte lanes, one lane write per cycle.
// Ports: clk, reset (async, active-high), bus (page_reg_loader_if.slave).
// Macro PAGE_LOADER_SKIP_EN adds in_be so only masked lanes are written.
module page_reg_loader
    import page_loader_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int ENTRY_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    page_reg_loader_if.slave bus
);

    if (LANES != 4) begin : g_lanes_chk
        $error("page_reg_loader: LANES must be 4");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WORD_W-1:0]  r_data;
    logic [ENTRY_W-1:0] r_entry;
    lane_mask_t         r_pend;
    logic [BYTE_W-1:0]  r_out_data;
    lane_mask_t         r_lane_en;
    logic [ENTRY_W-1:0] r_out_entry;
    logic               r_done;

    lane_mask_t         w_pend_nxt;
    logic [BYTE_W-1:0]  w_out_data_nxt;
    lane_mask_t         w_lane_en_nxt;
    logic [ENTRY_W-1:0] w_out_entry_nxt;
    logic               w_done_nxt;

    logic               w_ready;
    logic               w_accept;
    logic               w_issue;
    lane_mask_t         w_mask;
    lane_mask_t         w_src_mask;
    logic [WORD_W-1:0]  w_src_data;
    logic [ENTRY_W-1:0] w_src_entry;
    logic [1:0]         w_idx;
    lane_mask_t         w_en;
    logic               w_last;

    // r_pend holds lanes still to write after the one on the outputs,
    // so an empty mask in WRITE means the last write is showing now.
    assign w_ready  = !reset && (r_state == IDLE || r_pend == '0);
    assign w_accept = bus.in_valid && w_ready;
    assign w_issue  = w_accept || (r_state == WRITE && r_pend != '0);

    // A freshly accepted word is served straight from the input bus.
    assign w_src_mask  = w_accept ? w_mask       : r_pend;
    assign w_src_data  = w_accept ? bus.in_data  : r_data;
    assign w_src_entry = w_accept ? bus.in_entry : r_entry;

`ifdef PAGE_LOADER_SKIP_EN
    assign w_mask = bus.in_be;

    page_lane_pick u_pick (
        .i_mask (w_src_mask),
        .o_idx  (w_idx),
        .o_en   (w_en),
        .o_last (w_last)
    );
`else
    logic [1:0] r_cnt;
    logic [1:0] w_src_cnt;

    assign w_mask    = '1;
    assign w_src_cnt = w_accept ? 2'd0 : r_cnt;
    assign w_idx     = w_src_cnt;
    assign w_en      = lane_mask_t'(1) << w_src_cnt;
    assign w_last    = w_src_cnt == 2'd3;

    // Wraps 3 -> 0 after the last lane; that value is never consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 2'd0;
        end else if (w_issue) begin
            r_cnt <= w_src_cnt + 2'd1;
        end
    end
`endif

    always_comb begin
        w_state_nxt     = IDLE;
        w_pend_nxt      = '0;
        w_lane_en_nxt   = '0;
        w_done_nxt      = 1'b0;
        w_out_data_nxt  = r_out_data;
        w_out_entry_nxt = r_out_entry;
        if (w_issue) begin
            w_state_nxt     = WRITE;
            w_pend_nxt      = w_src_mask & ~w_en;
            w_lane_en_nxt   = w_en;
            w_done_nxt      = w_last;
            w_out_data_nxt  = w_src_data[BYTE_W*w_idx +: BYTE_W];
            w_out_entry_nxt = w_src_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pend      <= '0;
            r_lane_en   <= '0;
            r_done      <= 1'b0;
            r_out_data  <= '0;
            r_out_entry <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_lane_en   <= w_lane_en_nxt;
            r_done      <= w_done_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_entry <= w_out_entry_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_entry <= '0;
        end else if (w_accept) begin
            r_data  <= bus.in_data;
            r_entry <= bus.in_entry;
        end
    end

    assign bus.in_ready    = w_ready;
    assign bus.out_data    = r_out_data;
    assign bus.out_lane_en = r_lane_en;
    assign bus.out_entry   = r_out_entry;
    assign bus.busy        = r_state == WRITE;
    assign bus.done        = r_done;

endmodule

// File: tb/tb_page_reg_loader.sv
// Randomized and directed bench for page_reg_loader against a write-list model.
// Honors PAGE_LOADER_SKIP_EN for the lane-mask scenarios.
module tb_page_reg_loader;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    page_reg_loader_if #(.ENTRY_W(3)) bus ();

    page_reg_loader #(.LANES(4), .ENTRY_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model: each accepted word expands to its list of lane writes;
    // one record is shown per cycle, the final one carrying done.
    typedef struct packed {
        logic [3:0] en;
        logic [7:0] d;
        logic [2:0] e;
        logic       dn;
    } wr_t;

    wr_t m_q[$];
    wr_t m_cur;
    bit  m_act = 1'b0;

    task automatic model_clear();
        m_q.delete();
        m_act = 1'b0;
    endtask

    task automatic model_edge(input bit acc, input logic [31:0] d,
                              input logic [2:0] e, input logic [3:0] m);
        wr_t r;
        if (acc) begin
            for (int k = 0; k < 4; k++) begin
                if (m[k]) begin
                    r.en = 4'b0001 << k;
                    r.d  = d[8*k +: 8];
                    r.e  = e;
                    r.dn = 1'b0;
                    m_q.push_back(r);
                end
            end
            if (m_q.size() == 0) begin
                r.en = 4'b0000;
                r.d  = 8'h00;
                r.e  = e;
                r.dn = 1'b0;
                m_q.push_back(r);
            end
            r = m_q.pop_back();
            r.dn = 1'b1;
            m_q.push_back(r);
        end
        if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            m_act = 1'b1;
        end else begin
            m_act = 1'b0;
        end
    endtask

    function automatic logic [17:0] exp_vec();
        logic rdy;
        logic show_d;
        rdy    = !reset && m_q.size() == 0;
        show_d = m_act && m_cur.en != 4'b0;
        return {rdy,
                m_act ? m_cur.en : 4'b0,
                m_act && m_cur.dn,
                m_act,
                m_act ? m_cur.e : 3'b0,
                show_d ? m_cur.d : 8'h00};
    endfunction

    function automatic logic [17:0] obs_vec();
        logic show_d;
        show_d = m_act && m_cur.en != 4'b0;
        return {bus.in_ready, bus.out_lane_en, bus.done, bus.busy,
                m_act ? bus.out_entry : 3'b0,
                show_d ? bus.out_data : 8'h00};
    endfunction

    // Drive one cycle from a negedge, advance the model on the posedge,
    // and come back to the following negedge for sampling.
    task automatic tick(input bit v, input logic [31:0] d,
                        input logic [2:0] e, input logic [3:0] be,
                        output bit acc);
        logic [3:0] m;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_entry = e;
`ifdef PAGE_LOADER_SKIP_EN
        bus.in_be = be;
        m = be;
`else
        m = be | 4'hF;
`endif
        acc = v && !reset && m_q.size() == 0;
        @(posedge clk);
        model_edge(acc, d, e, m);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit acc;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_entry = '0;
`ifdef PAGE_LOADER_SKIP_EN
        bus.in_be = 4'hF;
`endif
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.in_ready, bus.out_lane_en, bus.done, bus.busy,
                 bus.out_entry, bus.out_data} !== 18'h0) begin
                errors++;
                $display("FAIL reset_outs cyc%0d got %h want 0", i,
                         {bus.in_ready, bus.out_lane_en, bus.done, bus.busy,
                          bus.out_entry, bus.out_data});
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        acc = 1'b0;
    endtask

    task automatic test_single();
        bit acc;
        logic [31:0] w;
        w = 32'hDDCCBBAA;
        tick(1'b1, w, 3'd5, 4'hF, acc);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_model T+%0d got %h want %h",
                         i + 1, obs_vec(), exp_vec());
            end
            checks++;
            if ({bus.out_lane_en, bus.out_data, bus.out_entry, bus.done} !==
                {4'b0001 << i, w[8*i +: 8], 3'd5, i == 3}) begin
                errors++;
                $display("FAIL single_lane T+%0d got %b/%h/%0d/%b", i + 1,
                         bus.out_lane_en, bus.out_data, bus.out_entry,
                         bus.done);
            end
            tick(1'b0, 32'h0, 3'd0, 4'hF, acc);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL single_idle got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        tick(1'b1, 32'hDDCCBBAA, 3'd5, 4'hF, acc);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (bus.in_ready !== (i == 4)) begin
                errors++;
                $display("FAIL stall_ready T+%0d got %b want %b",
                         i, bus.in_ready, i == 4);
            end
            tick(1'b1, 32'h44332211, 3'd2, 4'hF, acc);
        end
        checks++;
        if ({bus.out_lane_en, bus.out_data, bus.out_entry, bus.busy} !==
            {4'b0001, 8'h11, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first T+5 got %b/%h/%0d want 0001/11/2",
                     bus.out_lane_en, bus.out_data, bus.out_entry);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_model step%0d got %h want %h",
                         i, obs_vec(), exp_vec());
            end
            tick(1'b0, 32'h0, 3'd0, 4'hF, acc);
        end
    endtask

    task automatic test_midreset();
        bit acc;
        tick(1'b1, 32'hA5A55A5A, 3'd3, 4'hF, acc);
        tick(1'b0, 32'h0, 3'd0, 4'hF, acc);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.out_lane_en, bus.done, bus.busy, bus.in_ready} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_now got %b/%b/%b/%b want 0",
                     bus.out_lane_en, bus.done, bus.busy, bus.in_ready);
        end
        model_clear();
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 32'h0, 3'd0, 4'hF, acc);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midreset_quiet step%0d got %h want %h",
                         i, obs_vec(), exp_vec());
            end
        end
        tick(1'b1, 32'h0BADF00D, 3'd7, 4'hF, acc);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midreset_reload step%0d got %h want %h",
                         i, obs_vec(), exp_vec());
            end
            tick(1'b0, 32'h0, 3'd0, 4'hF, acc);
        end
    endtask

`ifdef PAGE_LOADER_SKIP_EN
    task automatic test_skip();
        bit acc;
        tick(1'b1, 32'h44332211, 3'd6, 4'b1010, acc);
        checks++;
        if ({bus.out_lane_en, bus.out_data, bus.done} !==
            {4'b0010, 8'h22, 1'b0}) begin
            errors++;
            $display("FAIL skip_b1 got %b/%h/%b want 0010/22/0",
                     bus.out_lane_en, bus.out_data, bus.done);
        end
        tick(1'b0, 32'h0, 3'd0, 4'h0, acc);
        checks++;
        if ({bus.out_lane_en, bus.out_data, bus.done} !==
            {4'b1000, 8'h44, 1'b1}) begin
            errors++;
            $display("FAIL skip_b3 got %b/%h/%b want 1000/44/1",
                     bus.out_lane_en, bus.out_data, bus.done);
        end
        tick(1'b0, 32'h0, 3'd0, 4'h0, acc);
        tick(1'b1, 32'h12345678, 3'd1, 4'b0000, acc);
        checks++;
        if ({bus.out_lane_en, bus.done} !== {4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL skip_empty got %b/%b want 0000/1",
                     bus.out_lane_en, bus.done);
        end
        tick(1'b0, 32'h0, 3'd0, 4'h0, acc);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL skip_after got %h want %h", obs_vec(), exp_vec());
        end
    endtask
`endif

    task automatic test_random();
        bit          acc;
        bit          v;
        bit          hold;
        logic [31:0] d;
        logic [2:0]  e;
        logic [3:0]  be;
        hold = 1'b0;
        v = 1'b0;
        d = '0;
        e = '0;
        be = 4'hF;
        for (int i = 0; i < 300; i++) begin
            if (!hold) begin
                v  = $urandom_range(0, 3) != 0;
                d  = $urandom;
                e  = 3'($urandom_range(0, 7));
                be = 4'($urandom_range(0, 15));
            end
            tick(v, d, e, be, acc);
            hold = v && !acc;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d got %h want %h",
                         i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_midreset();
`ifdef PAGE_LOADER_SKIP_EN
        test_skip();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
